mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Parametrised MEM/WB stage register: the successor of the fixed 32-bit register.
//  Carries WB control, rs/rt/dest addresses, ALU result and memory result into writeback.
//  Adds a valid/ready handshake, a 2-entry skid buffer for stall back-pressure,
//  synchronous flush and async reset. Sits between the MEM stage and the register-file
//  write port / forwarding unit.
// PARAMETERS
//  DATA_W       32  width of alu/mem result fields
//  ADDR_W       5   width of rs/rt/dest register addresses
//  CTRL_W       3   width of WB control bundle {MemtoReg, MemRead, RegWrite}
//  REGWRITE_BIT 0   index of RegWrite inside the WB bundle
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       sync flush: drop all held entries
//  in_valid   in   1       MEM stage presents an entry
//  in_ready   out  1       stage can accept an entry this cycle
//  WBin       in   CTRL_W  WB control
//  rsin/rtin  in   ADDR_W  source register addresses
//  regresin   in   ADDR_W  destination register
//  ALUresin   in   DATA_W  ALU result
//  MEMresin   in   DATA_W  load data
//  out_valid  out  1       WB entry valid
//  out_ready  in   1       writeback consumes the entry
//  WB,rs,rt,regres,ALUres,MEMres  out  as inputs  head-entry fields
//  occupancy  out  2       entries held, 0..2
// BEHAVIOUR
//  - Storage is a head register (drives the outputs) plus a skid register. State = occupancy:
//    EMPTY(0), ONE(1), FULL(2).
//  - in_ready = (occupancy != 2) && !rst. Depends only on state, with no combinational
//    path from out_ready.
//  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
//  - EMPTY: an accept loads the head and moves to ONE. Latency in->out is 1 cycle.
//  - ONE, accept and pop: the head reloads from the inputs and the state stays ONE.
//    This gives 1 entry/cycle throughput.
//  - ONE, pop only: goes to EMPTY.
//  - ONE, accept only: the input goes to skid and the state moves to FULL.
//  - FULL: no accept. A pop moves skid to the head and the state goes to ONE.
//  - Order is strictly FIFO; entries are never reordered or duplicated.
//  - out_valid = (occupancy != 0).
//  - WB output is forced to 0 whenever out_valid=0, so a bubble can never write the
//    register file. Other fields hold their last value when invalid.
//  - flush: both entries are invalidated at the next edge and occupancy goes to 0.
//    An accept or pop in the same cycle is ignored, so a flush overrides everything.
//  - rst, any time including mid-transfer: occupancy=0, out_valid=0, in_ready=0, and
//    WB, rs, rt, regres, ALUres, MEMres = 0. After rst deasserts, in_ready=1 at once.
//  - A write to register 0 passes through unchanged; suppressing it is the regfile's job.
// CONFIGURATION
//  MEMWB_FWD_EN defined:
//    - Adds inputs q_rs and q_rt [ADDR_W] and outputs hit_rs, hit_rt [1] and fwd_data [DATA_W].
//    - hit_x = out_valid && WB[REGWRITE_BIT] && regres != 0 && regres == q_x.
//      This is combinational from the head register.
//    - fwd_data = MemtoReg ? MEMres : ALUres.
//  MEMWB_FWD_EN undefined: these ports and this logic are absent.
// TESTING
//  - Reset mid-FULL: fill 2 entries, pulse rst async between edges -> out_valid=0,
//    occupancy=0 and all outputs 0 immediately; in_ready=1 after release.
//  - Streaming: out_ready=1, feed 8 back-to-back entries ALUres=1..8 ->
//    out_valid from cycle 1, ALUres 1..8 on consecutive cycles, in_ready never low.
//  - Stall: out_ready=0, push A=0x11, B=0x22 -> occupancy=2, in_ready=0, C held off.
//    Then out_ready=1 -> outputs A, B, C in order, no loss.
//  - Flush with simultaneous push: occupancy=1, assert flush, in_valid=1 (D=0x44) ->
//    next cycle occupancy=0, out_valid=0, WB=0; D never appears.
//  - Bubble safety: in_valid=0 with WBin=3'b001 -> WB stays 3'b000, out_valid=0.
//  - MEMWB_FWD_EN: head has regres=5, WB=3'b101, MEMres=0xDEAD, q_rs=5, q_rt=0 ->
//    hit_rs=1, hit_rt=0, fwd_data=0xDEAD. With regres=0 -> both hits are 0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB stage register with valid/ready handshake, 2-entry skid buffer, sync flush and async reset.
// Define MEMWB_FWD_EN to add the head-entry forwarding compare ports (q_rs/q_rt, hit_rs/hit_rt, fwd_data).
`timescale 1ns/1ps
module mem_wb_pipe_reg #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int CTRL_W       = 3,
    parameter int REGWRITE_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] WBin,
    input  logic [ADDR_W-1:0] rsin,
    input  logic [ADDR_W-1:0] rtin,
    input  logic [ADDR_W-1:0] regresin,
    input  logic [DATA_W-1:0] ALUresin,
    input  logic [DATA_W-1:0] MEMresin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] WB,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] regres,
    output logic [DATA_W-1:0] ALUres,
    output logic [DATA_W-1:0] MEMres,
    output logic [1:0]        occupancy
`ifdef MEMWB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              hit_rs,
    output logic              hit_rt,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int ENT_W = CTRL_W + 3 * ADDR_W + 2 * DATA_W;

    if (REGWRITE_BIT < 0 || REGWRITE_BIT >= CTRL_W) begin : g_bad_regwrite_bit
        $error("REGWRITE_BIT must index into the WB control bundle");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e              state_q;
    logic [ENT_W-1:0]  head_q;
    logic [ENT_W-1:0]  skid_q;
    logic [ENT_W-1:0]  in_ent;
    logic [CTRL_W-1:0] head_wb;
    logic              accept;
    logic              pop;

    assign in_ent = {WBin, rsin, rtin, regresin, ALUresin, MEMresin};

    // Ready depends on state only, so back-pressure never forms a path from out_ready.
    assign in_ready  = (state_q != FULL) && !rst;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= in_ent;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= in_ent;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end else if (accept) begin
                        skid_q  <= in_ent;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign {head_wb, rs, rt, regres, ALUres, MEMres} = head_q;

    // A bubble must never carry RegWrite into the register file.
    assign WB = out_valid ? head_wb : '0;

`ifdef MEMWB_FWD_EN
    assign hit_rs   = out_valid && WB[REGWRITE_BIT] && (regres != '0) && (regres == q_rs);
    assign hit_rt   = out_valid && WB[REGWRITE_BIT] && (regres != '0) && (regres == q_rt);
    assign fwd_data = WB[CTRL_W-1] ? MEMres : ALUres;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed scenarios plus random traffic against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_mem_wb_pipe_reg;

    typedef struct packed {
        logic [2:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  WBin = '0;
    logic [4:0]  rsin = '0, rtin = '0, regresin = '0;
    logic [31:0] ALUresin = '0, MEMresin = '0;
    logic        in_ready, out_valid;
    logic [2:0]  WB;
    logic [4:0]  rs, rt, regres;
    logic [31:0] ALUres, MEMres;
    logic [1:0]  occupancy;
`ifdef MEMWB_FWD_EN
    logic [4:0]  q_rs = '0, q_rt = '0;
    logic        hit_rs, hit_rt;
    logic [31:0] fwd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WBin(WBin), .rsin(rsin), .rtin(rtin), .regresin(regresin),
        .ALUresin(ALUresin), .MEMresin(MEMresin),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB(WB), .rs(rs), .rt(rt), .regres(regres),
        .ALUres(ALUres), .MEMres(MEMres), .occupancy(occupancy)
`ifdef MEMWB_FWD_EN
        , .q_rs(q_rs), .q_rt(q_rt), .hit_rs(hit_rs), .hit_rt(hit_rt), .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the stage is a FIFO of depth 2; the outputs show its front, or the last front when empty.
    ent_t q[$];
    ent_t last_head = '0;
    bit   m_acc, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last_head = '0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) q.push_back('{WBin, rsin, rtin, regresin, ALUresin, MEMresin});
            end
            if (q.size() > 0) last_head = q[0];
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            ent_t h;
            bit   ev;
            ev = (q.size() > 0);
            h  = ev ? q[0] : last_head;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(!rst && q.size() < 2));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("WB", 64'(WB), 64'(ev ? h.wb : 3'b000));
            chk("rs", 64'(rs), 64'(h.rs));
            chk("rt", 64'(rt), 64'(h.rt));
            chk("regres", 64'(regres), 64'(h.rd));
            chk("ALUres", 64'(ALUres), 64'(h.alu));
            chk("MEMres", 64'(MEMres), 64'(h.mem));
`ifdef MEMWB_FWD_EN
            chk("hit_rs", 64'(hit_rs), 64'(ev && h.wb[0] && h.rd != 0 && h.rd == q_rs));
            chk("hit_rt", 64'(hit_rt), 64'(ev && h.wb[0] && h.rd != 0 && h.rd == q_rt));
            chk("fwd_data", 64'(fwd_data), 64'((ev && h.wb[2]) ? h.mem : h.alu));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input logic [2:0] wb, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
        in_valid = v;
        WBin     = wb;
        rsin     = rd + 5'd1;
        rtin     = rd + 5'd2;
        regresin = rd;
        ALUresin = alu;
        MEMresin = mem;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        put(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        step();
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Async reset while FULL.
        out_ready = 1'b0;
        put(1'b1, 3'b111, 5'd9, 32'hA1, 32'hB1);
        step();
        put(1'b1, 3'b111, 5'd10, 32'hA2, 32'hB2);
        step();
        chk("full_occ", 64'(occupancy), 64'd2);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("amid_valid", 64'(out_valid), 64'd0);
        chk("amid_occ", 64'(occupancy), 64'd0);
        chk("amid_in_ready", 64'(in_ready), 64'd0);
        chk("amid_fields", 64'({WB, rs, rt, regres}), 64'd0);
        chk("amid_data", {ALUres, MEMres}, 64'd0);
        rst = 1'b0;
        #1;
        chk("arel_in_ready", 64'(in_ready), 64'd1);

        // Streaming: 8 back-to-back entries, one out per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(1'b1, 3'b001, 5'd3, 32'(i), 32'h0);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_alu", 64'(ALUres), 64'(i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", 64'(occupancy), 64'd0);

        // Stall: A, B fill the stage, C is held off, then all three drain in order.
        out_ready = 1'b0;
        put(1'b1, 3'b001, 5'd4, 32'h11, 32'h0);
        step();
        put(1'b1, 3'b001, 5'd4, 32'h22, 32'h0);
        step();
        chk("stall_occ", 64'(occupancy), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        put(1'b1, 3'b001, 5'd4, 32'h33, 32'h0);
        step();
        chk("stall_hold_occ", 64'(occupancy), 64'd2);
        chk("stall_head_A", 64'(ALUres), 64'h11);
        out_ready = 1'b1;
        step();
        chk("stall_out_B", 64'(ALUres), 64'h22);
        step();
        chk("stall_out_C", 64'(ALUres), 64'h33);
        in_valid = 1'b0;
        step();
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Flush with a simultaneous push: D must never appear.
        out_ready = 1'b0;
        put(1'b1, 3'b001, 5'd6, 32'h55, 32'h0);
        step();
        chk("flush_pre_occ", 64'(occupancy), 64'd1);
        flush = 1'b1;
        put(1'b1, 3'b001, 5'd7, 32'h44, 32'h0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_wb", 64'(WB), 64'd0);
        out_ready = 1'b1;
        step();
        chk("flush_no_D", 64'(ALUres), 64'h55);

        // Bubble safety.
        put(1'b0, 3'b001, 5'd8, 32'h99, 32'h0);
        step();
        chk("bubble_wb", 64'(WB), 64'd0);
        chk("bubble_valid", 64'(out_valid), 64'd0);

`ifdef MEMWB_FWD_EN
        out_ready = 1'b0;
        q_rs = 5'd5;
        q_rt = 5'd0;
        put(1'b1, 3'b101, 5'd5, 32'h1234, 32'hDEAD);
        step();
        in_valid = 1'b0;
        #1;
        chk("fwd_hit_rs", 64'(hit_rs), 64'd1);
        chk("fwd_hit_rt", 64'(hit_rt), 64'd0);
        chk("fwd_data", 64'(fwd_data), 64'hDEAD);
        drain();
        q_rs = 5'd0;
        put(1'b1, 3'b101, 5'd0, 32'h1234, 32'hDEAD);
        step();
        in_valid = 1'b0;
        #1;
        chk("fwd_r0_rs", 64'(hit_rs), 64'd0);
        chk("fwd_r0_rt", 64'(hit_rt), 64'd0);
`endif
        drain();

        // Random traffic checked every cycle by the model compare.
        for (int n = 0; n < 600; n++) begin
            put(($urandom % 4) != 0, 3'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom);
            rsin      = 5'($urandom);
            rtin      = 5'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 24) == 0;
`ifdef MEMWB_FWD_EN
            q_rs = 5'($urandom_range(0, 3));
            q_rt = 5'($urandom_range(0, 3));
`endif
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
